conv_maxpool: RTL and testbench

2x2 stride-2 max-pooling stage directly downstream of `conv`. It consumes the raster-ordered signed 32-bit convolution result stream (`dout`/`ovalid`/`done` of `conv`) and emits the pooled feature map in raster order.

- Layer 0 (`state`=0): 24x24 in, 12x12 out.
- Layer 1 (`state`=1): 8x8 in, 4x4 out.

---
 rtl/conv_maxpool_if.sv | 15 +
 rtl/conv_maxpool.sv | 116 +++++++++++
 tb/tb_conv_maxpool.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_maxpool_if.sv
// Sample stream between conv and the 2x2 max-pool stage.
// The master drives input samples and the slave returns pooled results.
interface conv_maxpool_if #(
    parameter int DW = 32
);
    logic [DW-1:0] din;
    logic          ivalid;
    logic          idone;
    logic [DW-1:0] dout;
    logic          ovalid;
    logic          done;

    modport master (output din, ivalid, idone, input  dout, ovalid, done);
    modport slave  (input  din, ivalid, idone, output dout, ovalid, done);
endinterface

// File: rtl/conv_maxpool.sv
// 2x2 stride-2 signed max-pool over a raster-ordered conv result stream.
// A horizontal pair register and a half-row line buffer feed one output per 2x2 block.
module conv_maxpool #(
    parameter int DW = 32,
    parameter int W0 = 24,
    parameter int W1 = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            state,
    conv_maxpool_if.slave   io,
    output logic            err
);
    localparam int MAXW = (W0 > W1) ? W0 : W1;
    localparam int CW   = $clog2(MAXW);
    localparam int LBD  = MAXW / 2;
    localparam logic [CW-1:0] W0_M1 = CW'(W0 - 1);
    localparam logic [CW-1:0] W1_M1 = CW'(W1 - 1);

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic          layer;
    logic [CW-1:0] col, row, n_m1;
    logic [CW-2:0] pair_idx;
    logic [DW-1:0] hreg, hmax, dout_q;
    logic [DW-1:0] lbuf [LBD];
    logic          ovalid_q, done_q;
    logic          accept, is_last, bad_done, out_fire, lbuf_wr;

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fsm_q <= IDLE;
        else     fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: if (start) fsm_d = RUN;
            RUN:  fsm_d = RUN;
            default: fsm_d = IDLE;
        endcase
        if (accept && (is_last || bad_done)) fsm_d = IDLE;
    end

    // The frame size comes from the live layer select only on the start edge.
    always_comb begin
        n_m1     = '0;
        accept   = 1'b0;
        is_last  = 1'b0;
        bad_done = 1'b0;
        out_fire = 1'b0;
        lbuf_wr  = 1'b0;
        pair_idx = col[CW-1:1];
        hmax     = smax(hreg, io.din);
        if (fsm_q == IDLE) n_m1 = state ? W1_M1 : W0_M1;
        else               n_m1 = layer ? W1_M1 : W0_M1;
        accept   = io.ivalid && ((fsm_q == RUN) || start);
        is_last  = (col == n_m1) && (row == n_m1);
        bad_done = io.idone && !is_last;
        out_fire = accept && !bad_done && col[0] && row[0];
        lbuf_wr  = accept && !bad_done && col[0] && !row[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer    <= 1'b0;
            col      <= '0;
            row      <= '0;
            hreg     <= '0;
            dout_q   <= '0;
            ovalid_q <= 1'b0;
            done_q   <= 1'b0;
            err      <= 1'b0;
        end else begin
            ovalid_q <= 1'b0;
            done_q   <= 1'b0;
            if (fsm_q == IDLE && start) layer <= state;
            if (accept) begin
                if (!col[0]) hreg <= io.din;
                if (bad_done) err <= 1'b1;
                if (out_fire) begin
                    dout_q   <= smax(lbuf[pair_idx], hmax);
                    ovalid_q <= 1'b1;
                    done_q   <= is_last;
                end
                if (is_last || bad_done) begin
                    col <= '0;
                    row <= '0;
                end else if (col == n_m1) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (fsm_q == IDLE) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // Every entry is rewritten on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lbuf_wr) lbuf[pair_idx] <= hmax;
    end

    assign io.dout   = dout_q;
    assign io.ovalid = ovalid_q;
    assign io.done   = done_q;
endmodule

// File: tb/tb_conv_maxpool.sv
// Directed bench for conv_maxpool: a 2D pooling model predicts every output,
// and a negedge monitor checks value, done flag and timing of each cycle.
module tb_conv_maxpool;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst, start, state, err;

    conv_maxpool_if #(.DW(DW)) bus ();

    conv_maxpool #(.DW(DW), .W0(24), .W1(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .state (state),
        .io    (bus),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint data;
        bit     done;
    } exp_t;

    exp_t   exp_q [$];
    longint got_q [$];
    int     done_cnt    = 0;
    int     vectors     = 0;
    int     miscompares = 0;
    bit     produces_now = 1'b0;
    bit     want_ovalid;
    longint last_dout    = 0;

    function automatic longint sampleVal(input int mode, input int i);
        case (mode)
            0:       return longint'(i);
            1:       return -longint'(i + 1);
            default: return 64'sd7;
        endcase
    endfunction

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Pooled outputs of an n x n frame; only blocks completed before `limit` are emitted.
    task automatic buildExpected(input int n, input int mode, input int err_at, input int cut_at);
        int limit;
        limit = n * n;
        if (err_at >= 0)      limit = err_at;
        else if (cut_at >= 0) limit = cut_at;
        for (int pr = 0; pr < n / 2; pr++) begin
            for (int pc = 0; pc < n / 2; pc++) begin
                int     base;
                longint m;
                exp_t   e;
                base = 2 * pr * n + 2 * pc;
                if (base + n + 1 < limit) begin
                    m = sampleVal(mode, base);
                    if (sampleVal(mode, base + 1) > m)     m = sampleVal(mode, base + 1);
                    if (sampleVal(mode, base + n) > m)     m = sampleVal(mode, base + n);
                    if (sampleVal(mode, base + n + 1) > m) m = sampleVal(mode, base + n + 1);
                    e.data = m;
                    e.done = (base + n + 1 == n * n - 1);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic applyStimulus(input bit layer, input int mode, input bit bubbles,
                                 input int err_at, input int cut_at, input bit keep_start);
        int n;
        n = layer ? 8 : 24;
        buildExpected(n, mode, err_at, cut_at);
        for (int i = 0; i < n * n; i++) begin
            if (cut_at >= 0 && i == cut_at) break;
            if (bubbles && i > 0) begin
                bus.ivalid   = 1'b0;
                bus.idone    = 1'b0;
                produces_now = 1'b0;
                @(posedge clk); #1;
            end
            state        = layer;
            start        = 1'b1;
            bus.din      = DW'(sampleVal(mode, i));
            bus.ivalid   = 1'b1;
            bus.idone    = (i == n * n - 1) || (i == err_at);
            produces_now = ((i / n) % 2 == 1) && ((i % n) % 2 == 1) && (i != err_at);
            @(posedge clk); #1;
            if (i == err_at) break;
        end
        bus.ivalid   = 1'b0;
        bus.idone    = 1'b0;
        produces_now = 1'b0;
        if (!keep_start) start = 1'b0;
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("drain", longint'(exp_q.size()), 0);
    endtask

    task automatic clearCapture();
        got_q.delete();
        done_cnt = 0;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) want_ovalid <= 1'b0;
        else     want_ovalid <= produces_now;
    end

    // Per-cycle monitor: timing, value, done flag and hold behaviour.
    always @(negedge clk) begin
        if (rst) begin
            last_dout = 0;
        end else begin
            checkOutput("ovalid_timing", longint'(bus.ovalid), longint'(want_ovalid));
            if (bus.ovalid === 1'b1) begin
                got_q.push_back(longint'($signed(bus.dout)));
                if (bus.done) done_cnt++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_output: got dout %0d, expected no output",
                             longint'($signed(bus.dout)));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("dout", longint'($signed(bus.dout)), e.data);
                    checkOutput("done", longint'(bus.done), longint'(e.done));
                    last_dout = e.data;
                end
            end else begin
                checkOutput("done_without_ovalid", longint'(bus.done), 0);
                checkOutput("dout_hold", longint'($signed(bus.dout)), last_dout);
            end
        end
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        state      = 1'b0;
        bus.din    = '0;
        bus.ivalid = 1'b0;
        bus.idone  = 1'b0;
        #12;
        checkOutput("reset_dout",   longint'($signed(bus.dout)), 0);
        checkOutput("reset_ovalid", longint'(bus.ovalid), 0);
        checkOutput("reset_done",   longint'(bus.done), 0);
        checkOutput("reset_err",    longint'(err), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] layer-0 ramp");
        clearCapture();
        applyStimulus(1'b0, 0, 1'b0, -1, -1, 1'b0);
        waitDrain();
        checkOutput("l0_count", longint'(got_q.size()), 144);
        checkOutput("l0_first", got_q[0], 25);
        checkOutput("l0_last",  got_q[got_q.size() - 1], 575);
        checkOutput("l0_dones", longint'(done_cnt), 1);
        checkOutput("l0_err",   longint'(err), 0);

        $display("[TB] ivalid/idone while idle and start low");
        bus.din    = DW'(99);
        bus.ivalid = 1'b1;
        bus.idone  = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.ivalid = 1'b0;
        bus.idone  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("idle_ignore_err", longint'(err), 0);

        $display("[TB] layer-1 negatives");
        clearCapture();
        applyStimulus(1'b1, 1, 1'b0, -1, -1, 1'b0);
        waitDrain();
        checkOutput("l1_count", longint'(got_q.size()), 16);
        checkOutput("l1_first", got_q[0], -1);
        checkOutput("l1_last",  got_q[got_q.size() - 1], -55);
        checkOutput("l1_dones", longint'(done_cnt), 1);

        $display("[TB] layer-0 ramp with bubbles");
        clearCapture();
        applyStimulus(1'b0, 0, 1'b1, -1, -1, 1'b0);
        waitDrain();
        checkOutput("bub_count", longint'(got_q.size()), 144);
        checkOutput("bub_first", got_q[0], 25);
        checkOutput("bub_last",  got_q[got_q.size() - 1], 575);

        $display("[TB] early idone on layer 1");
        clearCapture();
        applyStimulus(1'b1, 1, 1'b0, 30, -1, 1'b0);
        waitDrain();
        checkOutput("early_count", longint'(got_q.size()), 7);
        checkOutput("early_dones", longint'(done_cnt), 0);
        checkOutput("early_err",   longint'(err), 1);
        repeat (5) @(negedge clk);
        checkOutput("early_err_sticky", longint'(err), 1);
        clearCapture();
        applyStimulus(1'b1, 1, 1'b0, -1, -1, 1'b0);
        waitDrain();
        checkOutput("recover_count", longint'(got_q.size()), 16);
        checkOutput("recover_last",  got_q[got_q.size() - 1], -55);
        checkOutput("recover_dones", longint'(done_cnt), 1);
        checkOutput("recover_err",   longint'(err), 1);

        $display("[TB] reset mid-frame");
        clearCapture();
        applyStimulus(1'b0, 0, 1'b0, -1, 300, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("midrst_dout",   longint'($signed(bus.dout)), 0);
        checkOutput("midrst_ovalid", longint'(bus.ovalid), 0);
        checkOutput("midrst_done",   longint'(bus.done), 0);
        checkOutput("midrst_err",    longint'(err), 0);
        checkOutput("midrst_count",  longint'(got_q.size()), 72);
        checkOutput("midrst_queue",  longint'(exp_q.size()), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        clearCapture();
        applyStimulus(1'b0, 0, 1'b0, -1, -1, 1'b0);
        waitDrain();
        checkOutput("rerun_count", longint'(got_q.size()), 144);
        checkOutput("rerun_last",  got_q[got_q.size() - 1], 575);

        $display("[TB] back-to-back frames");
        clearCapture();
        applyStimulus(1'b0, 0, 1'b0, -1, -1, 1'b1);
        applyStimulus(1'b1, 2, 1'b0, -1, -1, 1'b0);
        waitDrain();
        checkOutput("b2b_count",  longint'(got_q.size()), 160);
        checkOutput("b2b_a_last", got_q[143], 575);
        checkOutput("b2b_b_first", got_q[144], 7);
        checkOutput("b2b_b_last", got_q[got_q.size() - 1], 7);
        checkOutput("b2b_dones",  longint'(done_cnt), 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
